nibble_word_packer: RTL and testbench
=====================================

Name: nibble_word_packer

Overview:
Upstream feeder for the registered nibble-array stage. It packs a stream of 4-bit nibbles into a WIDTH x 4-bit packed word, shape [WIDTH-1:0][3:0], and presents that word on a valid/ready interface. Downstream, the word is registered as in0, and RESET_VALUE is shared between the two stages. Short packets are flushed with in_last and padded.

Parameters:
- WIDTH, 8, nibbles per output word; legal range >= 2.
- RESET_VALUE, all zeros, type [WIDTH-1:0][3:0]; value of out_word while reset is asserted and afterwards until the first word is emitted.
- PAD_NIBBLE, 4'h0, type [3:0]; fill value for positions not written before in_last.
- CW, $clog2(WIDTH+1), derived local parameter; width of out_count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_nibble is valid.
- in_ready  output  1  packer accepts a nibble this cycle.
- in_nibble  input  4  nibble data.
- in_last  input  1  accepted nibble is the final nibble of a packet; flushes the word.
- out_valid  output  1  out_word, out_count and out_last are valid.
- out_ready  input  1  consumer accepts the word.
- out_word  output  [WIDTH-1:0][3:0]  packed word; nibble k is the k-th accepted nibble, so index 0 is first.
- out_count  output  CW  number of real nibbles in out_word, range 1..WIDTH.
- out_last  output  1  word closes a packet (flushed by in_last).

Behaviour:
- Clock and reset: reset is reset, synchronous, active-high; clock is clk.
- Reset values: out_valid=0, out_word=RESET_VALUE, out_count=0, out_last=0. Internal fill index idx=0 and accumulator acc=RESET_VALUE.
- Reset mid-packet discards all partial nibbles and any pending output word.
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a combinational path from out_ready to in_ready; it is intended and documented.
- State: idx (0..WIDTH-1) plus the out_valid flag.
- On an input accept that is not completing: acc[idx] <= in_nibble; idx <= idx+1.
- Completing accept: the accept is completing when idx==WIDTH-1 or in_last==1. On such an accept:
  - out_word[i] <= acc[i] for i<idx; in_nibble for i==idx; PAD_NIBBLE for i>idx.
  - out_count <= idx+1; out_last <= in_last; out_valid <= 1; idx <= 0.
- Latency: the word appears on the cycle after the completing accept. Throughput is 1 nibble/cycle when out_ready is held high, with no input bubbles across word boundaries.
- Output transfer without a completing accept in the same cycle: out_valid <= 0. out_word, out_count and out_last keep their values.
- Output transfer and completing accept in the same cycle: the new word loads and out_valid stays 1.
- While out_valid=1 and out_ready=0:
  - in_ready=0.
  - out_word, out_count and out_last are held stable; the valid/ready rule forbids any change.
- in_last at idx==WIDTH-1: a full word is emitted with out_count=WIDTH and out_last=1.
- in_last at idx==0: a single-nibble word is emitted with out_count=1 and WIDTH-1 pad nibbles.
- in_last and data are ignored unless an input accept occurs.
- idx wraps from WIDTH-1 to 0 only through the completing path; idx never reaches WIDTH.

Test Plan:
Bench parameters: WIDTH=4, RESET_VALUE=16'hA5A5, PAD_NIBBLE=4'hF.
1. Reset asserted 2 cycles -> out_valid=0, out_word=16'hA5A5, out_count=0, in_ready=1.
2. Nibbles 1,2,3,4 on consecutive cycles, out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_word=16'h4321, out_count=4, out_last=0.
3. Nibbles A then B with in_last=1 on B -> out_word=16'hFFBA, out_count=2, out_last=1; the next packet starts at idx 0.
4. Word pending with out_ready=0 for 5 cycles -> in_ready=0 throughout and out_word constant. Raise out_ready -> transfer occurs, in_ready=1 in that same cycle.
5. Eight nibbles 0..7 back-to-back with out_ready=1 -> 16'h3210 valid 1 cycle after the 4th accept, then 16'h7654 exactly 4 cycles later; in_ready never drops.
6. Accept 2 nibbles, assert reset 1 cycle, then send 5,6,7,8 -> output is 16'h8765; no pre-reset nibble appears.

Source files
------------

// File: rtl/nibble_word_packer.sv
// Packs a stream of 4-bit nibbles into WIDTH-nibble words on a valid/ready interface.
// Packets shorter than a word are flushed by in_last and the unused positions padded.
module nibble_word_packer #(
    parameter int                      WIDTH       = 8,
    parameter logic [WIDTH-1:0][3:0]   RESET_VALUE = '0,
    parameter logic [3:0]              PAD_NIBBLE  = 4'h0,
    localparam int                     CW          = $clog2(WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_nibble,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0][3:0]    out_word,
    output logic [CW-1:0]            out_count,
    output logic                     out_last
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IW-1:0]            idx_q, idx_d;
    logic [WIDTH-1:0][3:0]    acc_q, acc_d;
    logic [WIDTH-1:0][3:0]    out_word_q, out_word_d;
    logic [CW-1:0]            out_count_q, out_count_d;
    logic                     out_last_q, out_last_d;
    logic                     out_valid_q, out_valid_d;

    logic                     accept;
    logic                     complete;

    always_comb begin
        // out_ready reaches in_ready combinationally so a draining word never costs a bubble
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        complete    = accept && ((idx_q == IW'(WIDTH - 1)) || in_last);

        idx_d       = idx_q;
        acc_d       = acc_q;
        out_word_d  = out_word_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (complete) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (IW'(i) < idx_q) begin
                    out_word_d[i] = acc_q[i];
                end else if (IW'(i) == idx_q) begin
                    out_word_d[i] = in_nibble;
                end else begin
                    out_word_d[i] = PAD_NIBBLE;
                end
            end
            out_count_d = CW'(idx_q) + CW'(1);
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            idx_d       = '0;
        end else begin
            if (accept) begin
                acc_d[idx_q] = in_nibble;
                idx_d        = idx_q + IW'(1);
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            acc_q       <= RESET_VALUE;
            out_word_q  <= RESET_VALUE;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_word_q  <= out_word_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_word  = out_word_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nibble_word_packer.sv
// Randomized scoreboard bench for nibble_word_packer: a packet-level model queues
// expected words, and a monitor compares them whenever the DUT presents an output.
module tb_nibble_word_packer;

    localparam int               WIDTH = 4;
    localparam logic [15:0]      RV    = 16'hA5A5;
    localparam logic [3:0]       PAD   = 4'hF;

    typedef struct packed {
        logic [15:0] w;
        logic [2:0]  c;
        logic        l;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              in_nibble;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0][3:0]   out_word;
    logic [2:0]              out_count;
    logic                    out_last;

    int tests = 0;
    int fails = 0;

    exp_t       exp_q[$];
    logic [3:0] pkt[$];
    exp_t       hold;

    nibble_word_packer #(
        .WIDTH(WIDTH),
        .RESET_VALUE(RV),
        .PAD_NIBBLE(PAD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_nibble(in_nibble),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word(out_word),
        .out_count(out_count),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Packet-level reference: nibbles collect in arrival order; a word closes at WIDTH or on last.
    task automatic model_accept(input logic [3:0] nib, input logic last);
        exp_t e;
        pkt.push_back(nib);
        if (pkt.size() == WIDTH || last) begin
            e.w = '0;
            for (int k = 0; k < WIDTH; k++)
                e.w[k*4 +: 4] = (k < pkt.size()) ? pkt[k] : PAD;
            e.c = 3'(pkt.size());
            e.l = last;
            exp_q.push_back(e);
            hold = e;
            pkt.delete();
        end
    endtask

    task automatic model_reset();
        pkt.delete();
        exp_q.delete();
        hold.w = RV;
        hold.c = '0;
        hold.l = 1'b0;
    endtask

    // One clock: decide acceptance mid-cycle, update the model just after the edge.
    task automatic step(output logic accepted);
        logic       rs;
        logic [3:0] nib;
        logic       lst;
        @(negedge clk);
        rs       = reset;
        accepted = in_valid && in_ready && !reset;
        nib      = in_nibble;
        lst      = in_last;
        @(posedge clk);
        #1;
        if (rs) model_reset();
        else if (accepted) model_accept(nib, lst);
    endtask

    task automatic idle(input int n);
        logic a;
        in_valid = 1'b0;
        repeat (n) step(a);
    endtask

    task automatic send(input logic [3:0] nib, input logic last);
        logic a;
        int   budget;
        in_valid  = 1'b1;
        in_nibble = nib;
        in_last   = last;
        budget    = 0;
        a         = 1'b0;
        while (!a && budget < 100) begin
            step(a);
            budget++;
        end
        if (!a) begin
            fails++;
            $display("FAIL send_timeout actual=not_accepted required=accepted nibble=%0h", nib);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
            if (exp_q.size() != 0) begin
                chk("out_word", 32'(out_word), 32'(exp_q[0].w));
                chk("out_count", 32'(out_count), 32'(exp_q[0].c));
                chk("out_last", 32'(out_last), 32'(exp_q[0].l));
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                chk("held_word", 32'(out_word), 32'(hold.w));
                chk("held_count", 32'(out_count), 32'(hold.c));
                chk("held_last", 32'(out_last), 32'(hold.l));
            end
        end
    end

    initial begin
        logic a;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_nibble = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_reset();
        step(a);
        step(a);
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_word", 32'(out_word), 32'(RV));
        chk("rst_out_count", 32'(out_count), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        idle(1);

        for (int i = 1; i <= 4; i++) send(4'(i), 1'b0);
        idle(2);

        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        idle(2);

        out_ready = 1'b0;
        send(4'hC, 1'b0);
        send(4'hD, 1'b1);
        in_valid  = 1'b1;
        in_nibble = 4'h9;
        in_last   = 1'b0;
        repeat (5) step(a);
        out_ready = 1'b1;
        idle(2);

        for (int i = 0; i < 8; i++) send(4'(i), 1'b0);
        idle(2);

        send(4'h1, 1'b1);
        for (int i = 0; i < 4; i++) send(4'(i + 8), i == 3);
        idle(2);

        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        step(a);
        reset = 1'b0;
        for (int i = 5; i <= 8; i++) send(4'(i), 1'b0);
        idle(2);

        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_nibble = 4'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step(a);
        end
        out_ready = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
